// File: rtl/gf_inv_sequencer.sv
// gf_inv_sequencer: GF(2^8) multiplicative inverse (a^254) computed with one
// shared multiplier over a fixed 13-step square/multiply schedule.
// Optional macro SBOX_AFFINE_EN adds the AES affine transform so out_data
// becomes the full S-box value; with it undefined out_data is the raw inverse.
module gf_inv_sequencer #(
  parameter int         WIDTH = 8,
  parameter logic [8:0] POLY  = 9'h11B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [3:0] LAST_STEP = 4'd12;

  state_t           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // Multiplier operands: odd steps multiply by the original operand, even
  // steps (including the final step 12) square the running value.
  logic [WIDTH-1:0]   mul_x, mul_y, mul_res, res_out;
  logic [2*WIDTH-2:0] pp [WIDTH];
  logic [2*WIDTH-2:0] prod, red;

  assign mul_x = r_q;
  assign mul_y = step_q[0] ? a_q : r_q;

  // Carry-less partial products, one shifted copy of x per set bit of y.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = mul_y[gi] ? ({{(WIDTH-1){1'b0}}, mul_x} << gi) : '0;
    end
  endgenerate

  // XOR-accumulate the partial products, then fold the top bits back down
  // with the reduction polynomial, highest degree first.
  always_comb begin
    prod = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prod = prod ^ pp[i];
    end
    red = prod;
    for (int k = WIDTH-2; k >= 0; k--) begin
      if (red[WIDTH+k]) begin
        red = red ^ ({{(WIDTH-2){1'b0}}, POLY} << k);
      end
    end
    mul_res = red[WIDTH-1:0];
  end

`ifdef SBOX_AFFINE_EN
  // AES affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    res_out = mul_res
            ^ {mul_res[6:0], mul_res[7]}
            ^ {mul_res[5:0], mul_res[7:6]}
            ^ {mul_res[4:0], mul_res[7:5]}
            ^ {mul_res[3:0], mul_res[7:4]}
            ^ 8'h63;
  end
`else
  // Raw inverse straight from the multiplier.
  always_comb begin
    res_out = mul_res;
  end
`endif

  // Next-state logic: accept in IDLE, run the schedule in MUL, hold in DONE.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    r_d         = r_q;
    a_d         = a_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_data;
          r_d     = in_data;
          step_d  = 4'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        r_d = mul_res;
        if (step_q == LAST_STEP) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = res_out;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 4'd0;
      r_q         <= '0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      r_q         <= r_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // in_ready is held low while reset is asserted, whatever the state.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == MUL) || (state_q == DONE);

endmodule

// File: tb/tb_gf_inv_sequencer.sv
// Testbench for gf_inv_sequencer: known vectors, stall hold, mid-operation
// reset and an exhaustive sweep with random output back-pressure.
module tb_gf_inv_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q [$];

`ifdef SBOX_AFFINE_EN
  localparam logic [7:0] EXP_53 = 8'hED;
  localparam logic [7:0] EXP_00 = 8'h63;
  localparam logic [7:0] EXP_01 = 8'h7C;
  localparam logic [7:0] EXP_02 = 8'h77;
`else
  localparam logic [7:0] EXP_53 = 8'hCA;
  localparam logic [7:0] EXP_00 = 8'h00;
  localparam logic [7:0] EXP_01 = 8'h01;
  localparam logic [7:0] EXP_02 = 8'h8D;
`endif

  gf_inv_sequencer #(.WIDTH(8), .POLY(9'h11B)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: xtime-style multiply, brute-force inverse search,
  // bitwise FIPS-197 affine form.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x = x << 1;
      if (hi) x = x ^ 8'h1B;
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (ref_mul(a, 8'(b)) == 8'h01) return 8'(b);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_expected(input logic [7:0] a);
    logic [7:0] b = ref_inv(a);
`ifdef SBOX_AFFINE_EN
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int i = 0; i < 8; i++) begin
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    end
    return s;
`else
    return b;
`endif
  endfunction

  // Drive one operand for one cycle once in_ready is seen; returns at the
  // negedge right after the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] exp_val);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) $display("FAIL send_ready a=%02h in_ready=%0b required 1", a, in_ready);
    else passed++;
    in_valid = 1'b1;
    in_data  = a;
    exp_q.push_back(exp_val);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0)
      $display("FAIL reset_state in_ready=%b out_valid=%b out_data=%02h busy=%b required 0/0/00/0",
               in_ready, out_valid, out_data, busy);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required 1", in_ready);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_known(input logic [7:0] a, input logic [7:0] spec_val);
    int lat;
    logic [7:0] e;
    send(a, spec_val);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL known_busy a=%02h busy=%b in_ready=%b required 1/0", a, busy, in_ready);
    else passed++;
    wait_valid(lat);
    checks++;
    if (lat != 13) $display("FAIL known_latency a=%02h latency=%0d required 13", a, lat);
    else passed++;
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) $display("FAIL known_data a=%02h out_data=%02h required %02h", a, out_data, e);
    else passed++;
    $display("known a=%02h out=%02h exp=%02h lat=%0d", a, out_data, e, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL known_release a=%02h out_valid=%b in_ready=%b busy=%b required 0/1/0",
               a, out_valid, in_ready, busy);
    else passed++;
  endtask

  task automatic test_stall();
    int lat;
    logic [7:0] e;
    send(8'h02, EXP_02);
    wait_valid(lat);
    checks++;
    if (lat != 13) $display("FAIL stall_latency latency=%0d required 13", lat);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0] || in_ready !== 1'b0)
        $display("FAIL stall_hold cycle=%0d out_valid=%b out_data=%02h in_ready=%b required 1/%02h/0",
                 i, out_valid, out_data, in_ready, exp_q[0]);
      else passed++;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) $display("FAIL stall_data out_data=%02h required %02h", out_data, e);
    else passed++;
    $display("stall a=02 out=%02h exp=%02h", out_data, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    send(8'h53, 8'h00);
    void'(exp_q.pop_back());  // the aborted operand never produces a result
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0)
      $display("FAIL abort_reset in_ready=%b out_valid=%b out_data=%02h busy=%b required 0/0/00/0",
               in_ready, out_valid, out_data, busy);
    else passed++;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (seen) $display("FAIL abort_no_output out_valid seen=1 required 0");
    else passed++;
    $display("abort a=53 at step 6, output seen=%0b", seen);
    test_known(8'h02, EXP_02);
  endtask

  task automatic test_exhaustive();
    int hs = 0;
    logic [7:0] e;
    for (int a = 0; a < 256; a++) begin
      bit done = 1'b0;
      send(8'(a), ref_expected(8'(a)));
      for (int c = 0; c < 300 && !done; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        #1;
        if (out_valid && out_ready) begin
          e = exp_q.pop_front();
          checks++;
          if (out_data !== e) $display("FAIL exh_data a=%02h out_data=%02h required %02h", 8'(a), out_data, e);
          else passed++;
          $display("exh a=%02h out=%02h exp=%02h", 8'(a), out_data, e);
          hs++;
          done = 1'b1;
        end
        @(negedge clk);
      end
      out_ready = 1'b0;
      if (!done) begin
        checks++;
        $display("FAIL exh_timeout a=%02h out_valid=%b required 1", 8'(a), out_valid);
        void'(exp_q.pop_front());
      end
    end
    checks++;
    if (hs != 256 || exp_q.size() != 0)
      $display("FAIL exh_count handshakes=%0d pending=%0d required 256/0", hs, exp_q.size());
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_known(8'h53, EXP_53);
    test_known(8'h00, EXP_00);
    test_known(8'h01, EXP_01);
    test_stall();
    test_abort();
    test_exhaustive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
